// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared async_mem.
// Reads hold mem_read for READ_WAIT cycles so the combinational read delay elapses before capture.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned READ_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

  localparam logic [3:0] CntLoad = 4'(READ_WAIT - 1);

  state_e      r_state, w_state_d;
  logic        r_grant, w_grant_d;
  logic        r_last_grant, w_last_grant_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_ack0, r_ack1, r_busy, r_mem_read, r_mem_write;

  logic        w_req_any;
  logic        w_pick;
  logic        w_pick_we;
  logic [31:0] w_pick_addr;
  logic [31:0] w_pick_wdata;

  // On a tie the port not granted last wins; otherwise the lone requester.
  always_comb begin
    w_req_any    = req0 | req1;
    w_pick       = (req0 && req1) ? ~r_last_grant : req1;
    w_pick_we    = w_pick ? we1 : we0;
    w_pick_addr  = (w_pick ? addr1 : addr0) & ~32'h3;
    w_pick_wdata = w_pick ? wdata1 : wdata0;
  end

  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_last_grant_d = r_last_grant;
    w_cnt_d        = r_cnt;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_rdata_d      = r_rdata;
    unique case (r_state)
      StIdle: begin
        if (w_req_any) begin
          w_grant_d      = w_pick;
          w_last_grant_d = w_pick;
          w_addr_d       = w_pick_addr;
          w_wdata_d      = w_pick_wdata;
          if (w_pick_we) begin
            w_state_d = StWr;
          end else begin
            w_state_d = StRd;
            w_cnt_d   = CntLoad;
          end
        end
      end
      StWr: begin
        w_state_d = StDone;
      end
      StRd: begin
        if (r_cnt == 4'd0) begin
          w_rdata_d = mem_read_data;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_rdata      <= 32'h0;
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_last_grant <= w_last_grant_d;
      r_cnt        <= w_cnt_d;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_rdata      <= w_rdata_d;
    end
  end

  // Strobes and acks are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_ack0      <= (w_state_d == StDone) && !w_grant_d;
      r_ack1      <= (w_state_d == StDone) && w_grant_d;
      r_busy      <= (w_state_d != StIdle);
      r_mem_read  <= (w_state_d == StRd);
      r_mem_write <= (w_state_d == StWr);
    end
  end

  assign ack0           = r_ack0;
  assign ack1           = r_ack1;
  assign rdata          = r_rdata;
  assign busy           = r_busy;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_addr;
  assign mem_write_data = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with an async_mem model (7 ns read delay, 2.5 ns clock).
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #1.25 clk = ~clk;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_req1 = 0;
  logic [31:0] b_addr1 = 0;
  logic        b_ack0, b_ack1, b_busy, b_mem_read, b_mem_write;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.READ_WAIT(3)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_wdata), .mem_read_data(mem_rdata)
  );

  mem_arbiter #(.READ_WAIT(2)) u_dut_short (
    .clk(clk), .reset(reset),
    .req0(1'b0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
    .addr0(32'h0), .addr1(b_addr1), .wdata0(32'h0), .wdata1(32'h0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_write_data(b_mem_wdata), .mem_read_data(b_mem_rdata)
  );

  // Shared memory: synchronous write, read data valid 7 ns after strobe/address change.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write)   mem[mem_addr[9:2]]   <= mem_wdata;
    if (b_mem_write) mem[b_mem_addr[9:2]] <= b_mem_wdata;
  end
  always @(mem_read or mem_addr) begin
    mem_rdata <= 32'h0;
    if (mem_read) mem_rdata <= #7 mem[mem_addr[9:2]];
  end
  always @(b_mem_read or b_mem_addr) begin
    b_mem_rdata <= 32'h0;
    if (b_mem_read) b_mem_rdata <= #7 mem[b_mem_addr[9:2]];
  end

  typedef struct packed {
    logic        port;
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  task automatic expect_xact(input logic p, input logic rd, input logic [31:0] a,
                             input logic [31:0] d);
    exp_q.push_back('{port: p, is_rd: rd, addr: a, data: d});
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
  endtask

  // Waits for this port's ack, then acts on the edge that ends the ack cycle.
  task automatic wait_ack(input int p, input bit keep);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout_port%0d: got no ack, required ack within 40 cycles", p);
    end
    @(posedge clk);
    #0.2;
    if (!keep || !got) begin
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic xact(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input bit keep);
    issue(p, we, a, d);
    wait_ack(p, keep);
  endtask

  // Monitor: pops the expected transaction on every ack and checks its whole footprint.
  int          strobe_cnt = 0;
  logic [31:0] strobe_addr = 0;
  bit          prev_strobe = 0;
  exp_t        e;
  always @(negedge clk) begin
    if (!reset) begin
      strobe_cnt  = 0;
      prev_strobe = 0;
    end else begin
      if (ack0 && ack1) begin
        n_cmp++;
        n_fail++;
        $display("FAIL both_acks: got ack0=1 ack1=1, required at most one");
      end else if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack%0d with nothing pending, required none",
                   ack1 ? 1 : 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {31'h0, ack1}, {31'h0, e.port});
          chk("strobe_addr", strobe_addr, e.addr);
          chk("strobe_cycles", strobe_cnt, e.is_rd ? 32'd3 : 32'd1);
          chk("ack_follows_strobe", {31'h0, prev_strobe}, 32'd1);
          chk("done_outputs", {29'h0, busy, mem_read, mem_write}, 32'h4);
          if (e.is_rd) chk("read_data", rdata, e.data);
        end
        strobe_cnt = 0;
      end
      prev_strobe = mem_read || mem_write;
      if (prev_strobe) begin
        strobe_cnt++;
        strobe_addr = mem_addr;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish, required finish by 20000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with both masters already requesting.
    issue(0, 1'b1, 32'h10, 32'h1111_0001);
    issue(1, 1'b1, 32'h14, 32'h2222_0002);
    #3.1;
    chk("reset_ctrl", {27'h0, ack0, ack1, busy, mem_read, mem_write}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    expect_xact(1'b0, 1'b0, 32'h10, 32'h0);
    expect_xact(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    fork
      wait_ack(0, 0);
      wait_ack(1, 0);
    join

    // Both ports request continuously: grants alternate 0,1,0,1,0,1.
    expect_xact(1'b0, 1'b0, 32'h40, 32'h0);
    expect_xact(1'b1, 1'b0, 32'h80, 32'h0);
    expect_xact(1'b0, 1'b0, 32'h44, 32'h0);
    expect_xact(1'b1, 1'b1, 32'h80, 32'hB1B1_0001);
    expect_xact(1'b0, 1'b1, 32'h40, 32'hA1A1_0001);
    expect_xact(1'b1, 1'b1, 32'h44, 32'hA2A2_0002);
    fork
      begin
        xact(0, 1'b1, 32'h40, 32'hA1A1_0001, 1);
        xact(0, 1'b1, 32'h44, 32'hA2A2_0002, 1);
        xact(0, 1'b0, 32'h40, 32'h0, 0);
      end
      begin
        xact(1, 1'b1, 32'h80, 32'hB1B1_0001, 1);
        xact(1, 1'b0, 32'h80, 32'h0, 1);
        xact(1, 1'b0, 32'h44, 32'h0, 0);
      end
    join

    // Port 0 write to word 50, then port 1 reads it back.
    expect_xact(1'b0, 1'b0, 32'hC8, 32'h0);
    xact(0, 1'b1, 32'hC8, 32'hDEAD_BEEF, 0);
    chk("mem_word50", mem[50], 32'hDEAD_BEEF);
    expect_xact(1'b1, 1'b1, 32'hC8, 32'hDEAD_BEEF);
    xact(1, 1'b0, 32'hC8, 32'h0, 0);

    // Two wait states capture 5 ns after the strobe, before the data is valid.
    b_addr1 = 32'hC8;
    b_req1  = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = b_ack1;
      end
      n_cmp++;
      if (!got || b_rdata == 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL short_wait_read: got ack=%0d rdata=%h, required ack=1 rdata!=deadbeef",
                 got, b_rdata);
      end
      @(posedge clk);
      #0.2;
      b_req1 = 1'b0;
    end

    // Reset in the second RD cycle aborts the read with no ack.
    issue(1, 1'b0, 32'hC8, 32'h0);
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = mem_read;
      end
      chk("mid_rd_reached", {31'h0, seen}, 32'd1);
    end
    @(posedge clk);
    #0.6;
    reset = 1'b0;
    req1  = 1'b0;
    #0.1;
    chk("abort_ctrl", {27'h0, ack0, ack1, busy, mem_read, mem_write}, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_xact(1'b1, 1'b1, 32'hC8, 32'hDEAD_BEEF);
    xact(1, 1'b0, 32'hC8, 32'h0, 0);

    // Unaligned write lands on the aligned word and reads back at 0xC8.
    expect_xact(1'b0, 1'b0, 32'hC8, 32'h0);
    xact(0, 1'b1, 32'hCB, 32'h1234_5678, 0);
    chk("mem_word50_unaligned", mem[50], 32'h1234_5678);
    expect_xact(1'b1, 1'b1, 32'hC8, 32'h1234_5678);
    xact(1, 1'b0, 32'hC8, 32'h0, 0);

    repeat (4) @(negedge clk);
    chk("pending_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
